// File: rtl/stack_if.sv
// -----------------------------------------------------------------------------
// stack_if : core <-> stack controller request/response channel.
//   push, pop, push_data   core -> controller  (request, sampled when ready=1)
//   ready                  controller -> core  (controller idle, request accepted)
//   pop_data, pop_valid    controller -> core  (popped word, one-cycle strobe)
// master = core side, slave = stack controller side.
// -----------------------------------------------------------------------------
interface stack_if #(
  parameter int WIDTH = 16
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             ready;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;

  modport master (
    output push, pop, push_data,
    input  ready, pop_data, pop_valid
  );

  modport slave (
    input  push, pop, push_data,
    output ready, pop_data, pop_valid
  );
endinterface

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl : push/pop controller for the CPU hardware stack.
// Owns the stack pointer (count) and drives a single-port stack memory with a
// registered address / write enable / write data; memory read data is async.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   bus (stack_if.slave) push/pop/push_data in, ready/pop_data/pop_valid out
//   count               number of stored words, 0..NWORDS
//   empty, full         combinational from count
//   overflow, underflow sticky rejected-request flags, cleared by reset only
//   mem_a, mem_we, mem_din  registered stack memory controls
//   mem_dout            async read data, mem[mem_a]
//   tos, tos_valid      top-of-stack peek (only with STACK_PEEK_EN)
//
// Build option: define STACK_PEEK_EN to add the tos/tos_valid peek ports; the
// address is then parked on the top entry while idle.
// -----------------------------------------------------------------------------
module stack_ctrl #(
  parameter  int WIDTH  = 16,
  parameter  int NWORDS = 1024,
  localparam int AW     = $clog2(NWORDS)
) (
  input  logic             clk,
  input  logic             reset,
  stack_if.slave           bus,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [AW-1:0]    mem_a,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
`ifdef STACK_PEEK_EN
  ,
  output logic [WIDTH-1:0] tos,
  output logic             tos_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    XCH  = 2'd3
  } state_t;

  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(NWORDS);

  state_t        state_r;
  logic [AW-1:0] top_s;

  // Flags derived directly from the stack pointer.
  always_comb begin
    empty = (count == '0);
    full  = (count == FULL_CNT);
  end

  // Index of the current top entry; 0 when the stack is empty.
  always_comb begin
    if (count == '0) begin
      top_s = '0;
    end else begin
      top_s = AW'(count - ONE_CNT);
    end
  end

  assign bus.ready = (state_r == IDLE);

`ifdef STACK_PEEK_EN
  assign tos       = mem_dout;
  assign tos_valid = (state_r == IDLE) && !empty;
`endif

  // Request FSM: pointer, memory controls, pop response and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      count         <= '0;
      mem_a         <= '0;
      mem_we        <= 1'b0;
      mem_din       <= '0;
      bus.pop_data  <= '0;
      bus.pop_valid <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      mem_we        <= 1'b0;
      bus.pop_valid <= 1'b0;
      case (state_r)
        IDLE: begin
`ifdef STACK_PEEK_EN
          // Park on the top entry so tos follows count; an accepted op overrides.
          mem_a <= top_s;
`endif
          if (bus.push && (!bus.pop || empty)) begin
            // Plain push; push+pop on an empty stack also lands here.
            if (full) begin
              overflow <= 1'b1;
            end else begin
              mem_a   <= count[AW-1:0];
              mem_din <= bus.push_data;
              mem_we  <= 1'b1;
              state_r <= WR;
            end
          end else if (bus.pop && !bus.push) begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              mem_a   <= top_s;
              state_r <= RD;
            end
          end else if (bus.push && bus.pop) begin
            // Exchange: old top is read in XCH before the write edge lands.
            mem_a   <= top_s;
            mem_din <= bus.push_data;
            mem_we  <= 1'b1;
            state_r <= XCH;
          end else begin
            state_r <= IDLE;
          end
        end
        WR: begin
          count   <= count + ONE_CNT;
          state_r <= IDLE;
        end
        RD: begin
          bus.pop_data  <= mem_dout;
          bus.pop_valid <= 1'b1;
          count         <= count - ONE_CNT;
          state_r       <= IDLE;
        end
        XCH: begin
          bus.pop_data  <= mem_dout;
          bus.pop_valid <= 1'b1;
          state_r       <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl (NWORDS=4): stimulus pushes expected memory
// writes and pops into queues; a negedge monitor compares them as they appear.
module tb_stack_ctrl;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int AW = 2;

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } pop_e_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_e_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW:0]   count;
  logic          empty, full, overflow, underflow;
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [W-1:0]  mem_din, mem_dout;
  logic [W-1:0]  mem_m [N];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc   = 0;

  pop_e_t pop_q[$];
  wr_e_t  wr_q[$];

  stack_if #(.WIDTH(W)) bus();

  stack_ctrl #(.WIDTH(W), .NWORDS(N)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow),
    .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem_m[mem_a] <= mem_din;
  end
  assign mem_dout = mem_m[mem_a];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each write strobe and pop strobe against the scoreboard.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected mem_we", 32'(mem_a), 32'hFFFF_FFFF);
      end else begin
        wr_e_t e;
        e = wr_q.pop_front();
        chk("write addr", 32'(mem_a), 32'(e.a));
        chk("write data", 32'(mem_din), 32'(e.d));
      end
    end
    if (bus.pop_valid) begin
      if (pop_q.size() == 0) begin
        chk("unexpected pop_valid", 32'(bus.pop_data), 32'hFFFF_FFFF);
      end else begin
        pop_e_t e;
        e = pop_q.pop_front();
        chk("pop data", 32'(bus.pop_data), 32'(e.d));
        chk("pop latency", 32'(cyc), 32'(e.c));
      end
    end
  end

  // Issue one request when ready; queue the expected write/pop after acceptance.
  task automatic req(input logic p, input logic q, input logic [W-1:0] d,
                     input bit ew, input logic [AW-1:0] wa,
                     input bit ep, input logic [W-1:0] pd);
    int n;
    n = 0;
    while (!bus.ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ready) chk("ready timeout", 32'd0, 32'd1);
    bus.push = p;
    bus.pop = q;
    bus.push_data = d;
    @(posedge clk); #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    acc = cyc;
    if (ew) wr_q.push_back('{a: wa, d: d});
    if (ep) pop_q.push_back('{d: pd, c: acc + 1});
  endtask

  task automatic settle();
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.push_data = '0;
    do_reset();

    // Reset state
    chk("rst ready", 32'(bus.ready), 32'd1);
    chk("rst count", 32'(count), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst ovf", 32'(overflow), 32'd0);
    chk("rst unf", 32'(underflow), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_a", 32'(mem_a), 32'd0);
    chk("rst pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("rst pop_data", 32'(bus.pop_data), 32'd0);

    // Three pushes; ready drops for exactly one cycle after an accepted push
    req(1'b1, 1'b0, 16'h1111, 1'b1, 2'd0, 1'b0, 16'h0);
    chk("push busy", 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    chk("push ready again", 32'(bus.ready), 32'd1);
    req(1'b1, 1'b0, 16'h2222, 1'b1, 2'd1, 1'b0, 16'h0);
    req(1'b1, 1'b0, 16'h3333, 1'b1, 2'd2, 1'b0, 16'h0);
    settle();
    chk("count after 3 push", 32'(count), 32'd3);

    // Three pops in LIFO order
    req(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b1, 16'h3333);
    req(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b1, 16'h2222);
    req(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b1, 16'h1111);
    settle();
    chk("empty after pops", 32'(empty), 32'd1);
    chk("count after pops", 32'(count), 32'd0);

    // Pop on empty: rejected, sticky underflow
    req(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b0, 16'h0);
    chk("unf ready", 32'(bus.ready), 32'd1);
    chk("unf mem_we", 32'(mem_we), 32'd0);
    chk("unf set", 32'(underflow), 32'd1);
    settle();
    chk("unf sticky", 32'(underflow), 32'd1);
    chk("unf ovf clear", 32'(overflow), 32'd0);

    // Fill to NWORDS, then one more push
    do_reset();
    chk("unf cleared", 32'(underflow), 32'd0);
    req(1'b1, 1'b0, 16'hA001, 1'b1, 2'd0, 1'b0, 16'h0);
    req(1'b1, 1'b0, 16'hA002, 1'b1, 2'd1, 1'b0, 16'h0);
    req(1'b1, 1'b0, 16'hA003, 1'b1, 2'd2, 1'b0, 16'h0);
    settle();
    chk("not full at 3", 32'(full), 32'd0);
    req(1'b1, 1'b0, 16'hA004, 1'b1, 2'd3, 1'b0, 16'h0);
    settle();
    chk("full at 4", 32'(full), 32'd1);
    chk("count at 4", 32'(count), 32'd4);
    req(1'b1, 1'b0, 16'hA005, 1'b0, 2'd0, 1'b0, 16'h0);
    settle();
    chk("ovf count", 32'(count), 32'd4);
    chk("ovf set", 32'(overflow), 32'd1);
    chk("ovf ready", 32'(bus.ready), 32'd1);

    // Exchange: [A,B] push=pop=1 with C
    do_reset();
    chk("ovf cleared", 32'(overflow), 32'd0);
    req(1'b1, 1'b0, 16'h000A, 1'b1, 2'd0, 1'b0, 16'h0);
    req(1'b1, 1'b0, 16'h000B, 1'b1, 2'd1, 1'b0, 16'h0);
    req(1'b1, 1'b1, 16'h000C, 1'b1, 2'd1, 1'b1, 16'h000B);
    settle();
    chk("xch count", 32'(count), 32'd2);
    chk("xch mem1", 32'(mem_m[1]), 32'h000C);
    req(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b1, 16'h000C);
    req(1'b0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b1, 16'h000A);
    settle();
    chk("xch empty", 32'(empty), 32'd1);

    // push&pop on empty acts as a plain push
    req(1'b1, 1'b1, 16'h0055, 1'b1, 2'd0, 1'b0, 16'h0);
    settle();
    chk("pp empty count", 32'(count), 32'd1);
    chk("pp empty unf", 32'(underflow), 32'd0);

    // Reset while in WR abandons the push
    req(1'b1, 1'b0, 16'h0077, 1'b1, 2'd1, 1'b0, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("wr-rst mem_we", 32'(mem_we), 32'd0);
    chk("wr-rst count", 32'(count), 32'd0);
    chk("wr-rst ready", 32'(bus.ready), 32'd1);
    settle();

    chk("writes drained", 32'(wr_q.size()), 32'd0);
    chk("pops drained", 32'(pop_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
